output_driver_multi_blinker: RTL

- Multi-channel LED output driver for the health indicator.
- Each of NUM_CH channels independently drives one LED in one of four modes: OFF, SOLID, BLINK or BURST.
- BURST means N blinks followed by a dark pause, repeating.
- Sits between the health-status decode logic (which supplies enable/mode per channel) and the board LED pins.

---
 rtl/output_driver_multi_blinker_if.sv | 17 +
 rtl/output_driver_multi_blinker.sv | 127 ++++++++++++
 2 files changed

// File: rtl/output_driver_multi_blinker_if.sv
// output_driver_multi_blinker_if: per-channel LED control and status bundle
//   enable     : per-channel enable, bit i gates channel i
//   mode       : per-channel mode, bits [2i+1:2i] = 00 OFF, 01 SOLID, 10 BLINK, 11 BURST
//   led_out    : registered LED drive, 1 = lit
//   burst_done : one-cycle pulse in the last cycle of a burst+pause cycle
//   master drives enable/mode (health decode), slave is the LED driver
interface output_driver_multi_blinker_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]   enable;
    logic [2*NUM_CH-1:0] mode;
    logic [NUM_CH-1:0]   led_out;
    logic [NUM_CH-1:0]   burst_done;

    modport master (output enable, output mode, input led_out, input burst_done);
    modport slave  (input enable, input mode, output led_out, output burst_done);
endinterface

// File: rtl/output_driver_multi_blinker.sv
// output_driver_multi_blinker: independent OFF/SOLID/BLINK/BURST LED drivers
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of output_driver_multi_blinker_if (enable/mode in, led_out/burst_done out)
module output_driver_multi_blinker #(
    parameter int NUM_CH        = 4,
    parameter int CNT_W         = 24,
    parameter int BLINK_LIMIT   = 12500000,
    parameter int BURST_LEN     = 3,
    parameter int PAUSE_PERIODS = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    output_driver_multi_blinker_if.slave   bus
);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int PW = (PAUSE_PERIODS > 0) ? $clog2(PAUSE_PERIODS + 1) : 1;
    localparam logic [CNT_W-1:0] PH_END    = CNT_W'(BLINK_LIMIT - 1);
    localparam logic [BW-1:0]    BURST_END = BW'(BURST_LEN - 1);
    localparam logic [PW-1:0]    PAUSE_END = PW'(PAUSE_PERIODS - 1);
    localparam logic [1:0] M_OFF = 2'b00, M_SOLID = 2'b01, M_BURST = 2'b11;

    typedef enum logic [1:0] {IDLE, ON_PH, OFF_PH, PAUSE} state_t;

    logic [NUM_CH-1:0] led_vec, done_vec;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] phase_q, phase_d;
        logic [BW-1:0]    burst_q, burst_d;
        logic [PW-1:0]    pause_q, pause_d;
        logic [1:0]       mode_q, m;
        logic             led_q, done_q, done_d, on, start, phase_end;

        assign m         = bus.mode[2*g +: 2];
        assign on        = bus.enable[g] && m != M_OFF;
        // a mode change while running restarts the pattern just like leaving IDLE
        assign start     = on && (state_q == IDLE || m != mode_q);
        assign phase_end = phase_q == PH_END;

        always_comb begin
            state_d = state_q;
            phase_d = phase_q;
            burst_d = burst_q;
            pause_d = pause_q;
            if (!on) begin
                state_d = IDLE;
                phase_d = '0;
                burst_d = '0;
                pause_d = '0;
            end else if (start) begin
                state_d = ON_PH;
                phase_d = '0;
                burst_d = '0;
                pause_d = '0;
            end else begin
                case (state_q)
                    ON_PH: begin
                        if (m == M_SOLID) begin
                            phase_d = '0;
                        end else if (phase_end) begin
                            state_d = OFF_PH;
                            phase_d = '0;
                        end else begin
                            phase_d = phase_q + 1'b1;
                        end
                    end
                    OFF_PH: begin
                        if (!phase_end) begin
                            phase_d = phase_q + 1'b1;
                        end else begin
                            phase_d = '0;
                            state_d = ON_PH;
                            if (m == M_BURST && burst_q == BURST_END) begin
                                burst_d = '0;
                                pause_d = '0;
                                state_d = (PAUSE_PERIODS == 0) ? ON_PH : PAUSE;
                            end else begin
                                burst_d = (m == M_BURST) ? burst_q + 1'b1 : '0;
                            end
                        end
                    end
                    PAUSE: begin
                        if (!phase_end) begin
                            phase_d = phase_q + 1'b1;
                        end else begin
                            phase_d = '0;
                            pause_d = (pause_q == PAUSE_END) ? '0 : pause_q + 1'b1;
                            state_d = (pause_q == PAUSE_END) ? ON_PH : PAUSE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
            // outputs are registered, so decode the cycle the next state represents
            done_d = (state_d == PAUSE && phase_d == PH_END && pause_d == PAUSE_END) ||
                     (PAUSE_PERIODS == 0 && m == M_BURST && state_d == OFF_PH &&
                      phase_d == PH_END && burst_d == BURST_END);
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q <= IDLE;
                phase_q <= '0;
                burst_q <= '0;
                pause_q <= '0;
                mode_q  <= '0;
                led_q   <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                phase_q <= phase_d;
                burst_q <= burst_d;
                pause_q <= pause_d;
                mode_q  <= m;
                led_q   <= state_d == ON_PH;
                done_q  <= done_d;
            end
        end

        assign led_vec[g]  = led_q;
        assign done_vec[g] = done_q;
    end

    assign bus.led_out    = led_vec;
    assign bus.burst_done = done_vec;
endmodule
